// File: rtl/fpaddsub_align_stage.sv
`default_nettype none
// ============================================================================
// Module   : fpaddsub_align_stage
// Purpose  : Orders the operands by magnitude and right-aligns the smaller
//            significand with G/R/S bits behind a skid-buffered handshake.
// Revision : 1.0 - initial release
// ============================================================================
module fpaddsub_align_stage (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       Sa,
  input  logic       Sb,
  input  logic [5:0] ShiftDet,
  input  logic [4:0] InputExc,
  input  logic [6:0] Aout,
  input  logic [6:0] Bout,
  input  logic       Opout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] Mmax,
  output logic [7:0] Mmin,
  output logic [2:0] Emax,
  output logic       Sl,
  output logic       EffSub,
  output logic       Swap,
  output logic [4:0] Exc
);

  localparam int c_W = 27;

  logic       w_swap;
  logic [2:0] w_exp_max;
  logic [2:0] w_exp_min;
  logic [3:0] w_mant_max;
  logic [3:0] w_mant_min;
  logic [2:0] w_diff;
  logic [2:0] w_shift;
  logic [7:0] w_max_sig;
  logic [7:0] w_min_sig;
  logic [7:0] w_min_shr;
  logic [7:0] w_lost_mask;
  logic       w_sticky;
  logic       w_sl;
  logic [c_W-1:0] w_new;

  logic [c_W-1:0] r_or_data;
  logic           r_or_valid;
  logic [c_W-1:0] r_sk_data;
  logic           r_sk_valid;

  logic w_accept;
  logic w_drain;

  always_comb begin
    // {exp, mant} compares as one unsigned 7-bit magnitude
    w_swap     = (Bout > Aout);
    w_exp_max  = w_swap ? Bout[6:4] : Aout[6:4];
    w_mant_max = w_swap ? Bout[3:0] : Aout[3:0];
    w_exp_min  = w_swap ? Aout[6:4] : Bout[6:4];
    w_mant_min = w_swap ? Aout[3:0] : Bout[3:0];
    w_diff     = w_swap ? ShiftDet[5:3] : ShiftDet[2:0];

    // A denormal smaller operand has an implicit exponent of 1, not 0
    if ((w_exp_min == 3'd0) && (w_exp_max != 3'd0))
      w_shift = w_diff - 3'd1;
    else
      w_shift = w_diff;

    w_max_sig   = {(|w_exp_max), w_mant_max, 3'b000};
    w_min_sig   = {(|w_exp_min), w_mant_min, 3'b000};
    w_min_shr   = w_min_sig >> w_shift;
    w_lost_mask = ~(8'hFF << w_shift);
    w_sticky    = |(w_min_sig & w_lost_mask);

    w_sl  = w_swap ? (Sb ^ Opout) : Sa;
    w_new = {w_max_sig,
             w_min_shr[7:1], (w_min_shr[0] | w_sticky),
             w_exp_max, w_sl, (Sa ^ Sb ^ Opout), w_swap, InputExc};
  end

  assign in_ready = rst_n & ~r_sk_valid;
  assign w_accept = in_valid & in_ready;
  assign w_drain  = r_or_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_or_data  <= '0;
      r_or_valid <= 1'b0;
      r_sk_data  <= '0;
      r_sk_valid <= 1'b0;
    end else if (!r_or_valid || (w_drain && !r_sk_valid)) begin
      r_or_valid <= w_accept;
      if (w_accept)
        r_or_data <= w_new;
    end else if (w_drain && r_sk_valid) begin
      r_or_data  <= r_sk_data;
      r_or_valid <= 1'b1;
      r_sk_valid <= w_accept;
      if (w_accept)
        r_sk_data <= w_new;
    end else if (w_accept) begin
      r_sk_data  <= w_new;
      r_sk_valid <= 1'b1;
    end
  end

  assign out_valid = r_or_valid;
  assign {Mmax, Mmin, Emax, Sl, EffSub, Swap, Exc} = r_or_data;

endmodule
`default_nettype wire

// File: tb/tb_fpaddsub_align_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpaddsub_align_stage
// Purpose  : Directed and random checks of the alignment stage against an
//            arithmetic reference model and a FIFO scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpaddsub_align_stage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       Sa = 1'b0;
  logic       Sb = 1'b0;
  logic       Opout = 1'b0;
  logic [5:0] ShiftDet = '0;
  logic [4:0] InputExc = '0;
  logic [6:0] Aout = '0;
  logic [6:0] Bout = '0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] Mmax;
  logic [7:0] Mmin;
  logic [2:0] Emax;
  logic       Sl;
  logic       EffSub;
  logic       Swap;
  logic [4:0] Exc;
  logic [26:0] w_obs;

  int checks = 0;
  int failures = 0;
  logic [26:0] q[$];

  fpaddsub_align_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .Sa(Sa), .Sb(Sb), .ShiftDet(ShiftDet), .InputExc(InputExc),
    .Aout(Aout), .Bout(Bout), .Opout(Opout),
    .out_valid(out_valid), .out_ready(out_ready),
    .Mmax(Mmax), .Mmin(Mmin), .Emax(Emax), .Sl(Sl), .EffSub(EffSub),
    .Swap(Swap), .Exc(Exc)
  );

  assign w_obs = {Mmax, Mmin, Emax, Sl, EffSub, Swap, Exc};

  always #5 clk = ~clk;

  // Reference: significands as integers, alignment as division with remainder
  function automatic logic [26:0] model(input logic sa, input logic sb,
                                        input logic op, input logic [6:0] a,
                                        input logic [6:0] b,
                                        input logic [5:0] sd,
                                        input logic [4:0] exc);
    int ia, ib, el, ml, es, ms, d, sh, full, res, mx, sw, sl;
    ia = a; ib = b;
    sw = (ib > ia) ? 1 : 0;
    el = (sw ? ib : ia) / 16; ml = (sw ? ib : ia) % 16;
    es = (sw ? ia : ib) / 16; ms = (sw ? ia : ib) % 16;
    d  = sw ? (sd / 8) : (sd % 8);
    sh = (es == 0 && el != 0) ? ((d + 7) % 8) : d;
    mx   = ((el != 0) ? 16 : 0) + ml;
    full = (((es != 0) ? 16 : 0) + ms) * 8;
    res  = full / (1 << sh);
    if ((full % (1 << sh)) != 0) res = res | 1;
    sl = sw ? (sb ^ op) : sa;
    return {8'(mx * 8), 8'(res), 3'(el), 1'(sl), (sa ^ sb ^ op), 1'(sw), exc};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] a, input logic [6:0] b,
                       input logic sa, input logic sb, input logic op,
                       input logic [4:0] exc);
    logic [2:0] ea, eb;
    ea = a[6:4]; eb = b[6:4];
    Aout = a; Bout = b; Sa = sa; Sb = sb; Opout = op; InputExc = exc;
    ShiftDet = {3'(eb - ea), 3'(ea - eb)};
  endtask

  task automatic drive_rand();
    drive(7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
          1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom));
  endtask

  // One clock: check handshake state and data at negedge, then advance
  task automatic tick();
    logic acc, drn;
    @(negedge clk);
    if (rst_n) begin
      check("out_valid", out_valid, (q.size() != 0));
      check("in_ready", in_ready, (q.size() < 2));
      acc = in_valid && (q.size() < 2);
      drn = out_ready && (q.size() != 0);
      if (drn) begin
        check("data", w_obs, q[0]);
        void'(q.pop_front());
      end
      if (acc) q.push_back(model(Sa, Sb, Opout, Aout, Bout, ShiftDet, InputExc));
    end
    @(posedge clk); #1;
    if (!rst_n) q.delete();
  endtask

  initial begin
    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready_low", in_ready, 0);
    check("rst_data", w_obs, 0);
    rst_n = 1'b1;
    tick();

    // Simple add
    out_ready = 1'b1;
    drive(7'h35, 7'h12, 1'b0, 1'b0, 1'b0, 5'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("add_valid", out_valid, 1);
    check("add_swap", Swap, 0);
    check("add_emax", Emax, 3);
    check("add_mmax", Mmax, 8'hA8);
    check("add_mmin", Mmin, 8'h24);
    check("add_effsub", EffSub, 0);
    check("add_sl", Sl, 0);
    tick();

    // Swap
    drive(7'h12, 7'h35, 1'b0, 1'b1, 1'b0, 5'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("swap_swap", Swap, 1);
    check("swap_mmax", Mmax, 8'hA8);
    check("swap_mmin", Mmin, 8'h24);
    check("swap_effsub", EffSub, 1);
    check("swap_sl", Sl, 1);
    tick();

    // Denormal smaller operand with sticky
    drive(7'h60, 7'h0F, 1'b0, 1'b0, 1'b0, 5'h15);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("den_mmin", Mmin, 8'h03);
    check("den_mmax", Mmax, 8'h80);
    check("den_emax", Emax, 6);
    check("den_exc", Exc, 5'h15);
    tick();

    // Backpressure: three pushes, third refused until space returns
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      tick();
    end
    check("bp_in_ready_full", in_ready, 0);
    out_ready = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("bp_drained", q.size(), 0);

    // Streaming
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_rand();
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();

    // Random traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      drive_rand();
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    tick();

    // Reset with two items buffered
    out_ready = 1'b0;
    in_valid = 1'b1;
    drive_rand();
    tick();
    drive_rand();
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_data", w_obs, 0);
    rst_n = 1'b1;
    tick();
    drive(7'h35, 7'h12, 1'b1, 1'b0, 1'b1, 5'd3);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fpaddsub_align_stage.md
# fpaddsub_align_stage

Registered alignment stage of the 8-bit floating-point add/sub pipeline. It sits directly downstream of the pre-alignment stage and consumes that stage's outputs: signs, exponent differences, exception flags, unpacked operands and operation. It orders the operands by magnitude, restores hidden bits and right-shifts the smaller significand with guard/round/sticky bits. Results are held behind a valid/ready handshake with a one-entry skid buffer for the normaliser/adder stage. Number format is sign[7], exponent[6:4], mantissa[3:0].

## Interface
- No parameters; all widths are fixed by the 8-bit format.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  upstream data valid
- in_ready  out  1  stage can accept
- Sa, Sb  in  1 each  operand signs
- ShiftDet  in  6  {ExpB−ExpA, ExpA−ExpB}, each mod 8
- InputExc  in  5  {any, ANaN, BNaN, AInf, BInf}
- Aout, Bout  in  7 each  {exp[2:0], mant[3:0]}
- Opout  in  1  0 = add, 1 = subtract
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- Mmax  out  8  larger significand {hidden, mant, 3'b000}
- Mmin  out  8  aligned smaller significand {hidden, mant, G, R, S}
- Emax  out  3  exponent of the larger operand
- Sl  out  1  sign of the larger operand
- EffSub  out  1  Sa ^ Sb ^ Opout
- Swap  out  1  1 when B is the larger operand
- Exc  out  5  InputExc passed through

## Operation
- **Magnitude compare:** Swap = ({ExpB, MantB} > {ExpA, MantA}). On a tie, A is the larger operand and Swap = 0.
- **Difference selection:** d = Swap ? ShiftDet[5:3] : ShiftDet[2:0], always in the range 0..7.
- **Hidden bit:** hidden bit = |exp.
- **Denormal shift correction:** if the smaller exponent is 0 and the larger exponent is non-zero, the effective shift is d−1. Otherwise it is d.
- **Alignment shift:** Mmin = {hidden, mant, 3'b000} >> shift. Bit 0 is sticky: it is the OR of the original bit 0 and every bit shifted below position 0.
- **Sign of larger operand:** Sl = Swap ? (Sb ^ Opout) : Sa.
- **Exceptions:** exception inputs are not acted on. Exc is carried alongside the data unchanged, and datapath outputs are still computed.
- **Datapath:** purely combinational from the inputs into the capture registers.
- **Storage:** one output register (OR) and one skid register (SK), each with a valid bit.
- **in_ready** = ~SK.valid, forced to 0 while rst_n = 0.
- **Each cycle** (accept = in_valid & in_ready; drain = out_valid & out_ready):
  - OR empty, or drain with SK empty: OR loads the new item if accept.
  - drain with SK full: OR loads SK. If accept, SK loads the new item, otherwise SK is cleared.
  - OR full, no drain, accept: SK loads the new item.
- **Ordering:** outputs come out in strict FIFO order; nothing is lost or duplicated.
- **Output stability:** all data outputs are driven from OR and are stable while out_valid = 1 and out_ready = 0.

## Timing
- **Reset:** rst_n low at a clock edge clears OR.valid and SK.valid. The data registers are cleared to 0. After that edge:
  - out_valid = 0, and Mmax, Mmin, Emax, Sl, EffSub, Swap, Exc all read 0.
  - in_ready = 1 from the first cycle with rst_n high.
- **Latency:** 1 cycle. An item accepted at edge N appears on out_valid after edge N.
- **Throughput:** 1 item per cycle with out_ready held at 1.
- **Backpressure:** in_ready falls in the cycle after SK fills. At most 2 items are held.
- **Full-buffer release:** if out_ready rises while both registers are full, SK moves to OR at that edge. in_ready returns to 1 in the following cycle.
- **Accept and drain in the same cycle:** with SK empty, OR is replaced with no bubble.
- **Reset mid-operation:** buffered items are discarded. No output handshake completes on the reset edge.

## Test plan
- **Simple add:** Aout = 0x35, Bout = 0x12, Sa = Sb = 0, Opout = 0. Required: Swap = 0, Emax = 3, Mmax = 0xA8, Mmin = 0x24, EffSub = 0, Sl = 0, one cycle after accept.
- **Swap:** Aout = 0x12, Bout = 0x35, Sb = 1, Opout = 0. Required: Swap = 1, Mmax = 0xA8, Mmin = 0x24, EffSub = 1, Sl = 1.
- **Denormal and sticky:** Aout = 0x60, Bout = 0x0F. Required: effective shift 5, Mmin = 0x03 (sticky set), Mmax = 0x80, Emax = 6.
- **Backpressure:** out_ready = 0, push 3 items on consecutive cycles. Required: first two accepted, in_ready = 0 on the third. Then raise out_ready: items emerge in order 1, 2, 3 with no loss.
- **Streaming:** out_ready = 1, 8 back-to-back items. Required: out_valid continuous for 8 cycles; every output matches the reference model.
- **Reset mid-stream:** pull rst_n low with 2 items buffered. Required: out_valid = 0 and all outputs 0 after the edge; in_ready = 1 once rst_n is high; the next item behaves normally.
